// File: rtl/capture_tile.sv
`default_nettype none
// ============================================================================
//  Module      : capture_tile
//  Description : Copies the TILE_W x TILE_H background region under a sprite
//                from the framebuffer into a row-major tile buffer so it can
//                be restored once the sprite moves away.
//  Revision    : 1.0  initial release
// ============================================================================
module capture_tile #(
    parameter int TILE_W   = 20,
    parameter int TILE_H   = 20,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  origin_x,
    input  logic [6:0]  origin_y,
    output logic [14:0] fb_addr,
    input  logic [8:0]  fb_q,
    output logic [8:0]  buf_addr,
    output logic [8:0]  buf_data,
    output logic        buf_wren,
    output logic        busy,
    output logic        done
);

    localparam int c_NPIX = TILE_W * TILE_H;
    localparam int c_CW   = $clog2(TILE_W);
    localparam int c_RW   = $clog2(TILE_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [7:0]        r_ox;
    logic [6:0]        r_oy;
    logic [c_CW-1:0]   r_cx;
    logic [c_RW-1:0]   r_cy;
    logic [8:0]        r_k;
    logic [1:0]        r_drain;
    // stage-1 side information travelling alongside fb_addr
    logic              r_v1;
    logic [8:0]        r_k1;
    logic              r_clip1;

    logic [7:0]        w_ox;
    logic [6:0]        w_oy;
    logic [8:0]        w_px;
    logic [8:0]        w_py;
    logic              w_clip;
    logic [14:0]       w_lin;
    logic              w_issue;
    logic              w_last;
    logic              w_row_end;

    // Pixel 0 is issued on the accepting edge itself, so the origin comes
    // straight from the ports while idle and from the latched copy afterwards.
    always_comb begin
        w_ox      = (r_state == S_IDLE) ? origin_x : r_ox;
        w_oy      = (r_state == S_IDLE) ? origin_y : r_oy;
        w_px      = {1'b0, w_ox} + 9'(r_cx);
        w_py      = {2'b0, w_oy} + 9'(r_cy);
        w_clip    = (w_px >= 9'(SCREEN_W)) || (w_py >= 9'(SCREEN_H));
        w_lin     = 15'(w_py) * 15'(SCREEN_W) + 15'(w_px);
        w_issue   = ((r_state == S_IDLE) && start) || (r_state == S_READ);
        w_last    = (r_k == 9'(c_NPIX - 1));
        w_row_end = (r_cx == c_CW'(TILE_W - 1));
    end

    // Control FSM, read-address issue (stage 1) and buffer write (stage 2).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_ox     <= '0;
            r_oy     <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_k      <= '0;
            r_drain  <= '0;
            r_v1     <= 1'b0;
            r_k1     <= '0;
            r_clip1  <= 1'b0;
            fb_addr  <= '0;
            buf_addr <= '0;
            buf_data <= '0;
            buf_wren <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // stage 2: fb_q belongs to the address registered last edge
            buf_wren <= r_v1;
            if (r_v1) begin
                buf_addr <= r_k1;
                buf_data <= r_clip1 ? 9'h000 : fb_q;
            end

            r_v1 <= 1'b0;
            done <= 1'b0;

            // stage 1: present one pixel address per cycle
            if (w_issue) begin
                fb_addr <= w_clip ? 15'd0 : w_lin;
                r_k1    <= r_k;
                r_clip1 <= w_clip;
                r_v1    <= 1'b1;
                if (w_last) begin
                    r_cx <= '0;
                    r_cy <= '0;
                    r_k  <= '0;
                end else begin
                    r_k <= r_k + 9'd1;
                    if (w_row_end) begin
                        r_cx <= '0;
                        r_cy <= r_cy + 1'b1;
                    end else begin
                        r_cx <= r_cx + 1'b1;
                    end
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ox    <= origin_x;
                        r_oy    <= origin_y;
                        busy    <= 1'b1;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_last) begin
                        r_drain <= '0;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // the final write lands while draining; finish two edges later
                    if (r_drain == 2'd2) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_capture_tile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_capture_tile
//  Description : Self-checking bench for capture_tile with a framebuffer
//                model and a pixel-level reference of the captured tile.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_capture_tile;

    localparam int c_FB_SIZE = 160 * 120;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [7:0]  origin_x;
    logic [6:0]  origin_y;
    logic [14:0] fb_addr;
    logic [8:0]  fb_q;
    logic [8:0]  buf_addr;
    logic [8:0]  buf_data;
    logic        buf_wren;
    logic        busy;
    logic        done;

    logic [8:0]  fb [0:c_FB_SIZE-1];
    logic [17:0] wq [$];
    int          cyc;
    int          done_cnt;
    int          max_fb;
    int          checks;
    int          failures;

    capture_tile dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .origin_x (origin_x),
        .origin_y (origin_y),
        .fb_addr  (fb_addr),
        .fb_q     (fb_q),
        .buf_addr (buf_addr),
        .buf_data (buf_data),
        .buf_wren (buf_wren),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // framebuffer read data aligned with the presented address
    always_comb fb_q = (int'(fb_addr) < c_FB_SIZE) ? fb[fb_addr] : 9'h000;

    always @(posedge clk) cyc <= cyc + 1;

    // collect buffer writes, done pulses and the largest framebuffer address
    always @(negedge clk) begin
        if (buf_wren === 1'b1) wq.push_back({buf_addr, buf_data});
        if (done === 1'b1) done_cnt = done_cnt + 1;
        if (int'(fb_addr) > max_fb) max_fb = int'(fb_addr);
    end

    // expected tile pixel k for a capture anchored at (ox, oy)
    function automatic logic [8:0] model(input int ox, input int oy, input int k);
        int px, py;
        px = ox + (k % 20);
        py = oy + (k / 20);
        if (px >= 160 || py >= 120) return 9'h000;
        return fb[py * 160 + px];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag, input int ox, input int oy, input int base);
        int errs;
        logic [17:0] e;
        errs = 0;
        for (int k = 0; k < 400; k++) begin
            if (base + k >= wq.size()) begin
                errs++;
            end else begin
                e = wq[base + k];
                if (e[17:9] !== 9'(k) || e[8:0] !== model(ox, oy, k)) errs++;
            end
        end
        check({tag, "_write_errors"}, 32'(errs), 32'd0);
    endtask

    task automatic wait_done(input string tag, output int dcyc);
        int n;
        n = 0;
        dcyc = -1;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                dcyc = cyc;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(dcyc >= 0), 32'd1);
    endtask

    task automatic launch(input int ox, input int oy, output int e0);
        @(negedge clk);
        origin_x = 8'(ox);
        origin_y = 7'(oy);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0    = cyc;
    endtask

    task automatic capture(input int ox, input int oy, input string tag);
        int e0, d, dc0;
        wq.delete();
        dc0 = done_cnt;
        launch(ox, oy, e0);
        wait_done(tag, d);
        check({tag, "_latency"}, 32'(d - e0), 32'd402);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_nwrites"}, 32'(wq.size()), 32'd400);
        check_writes(tag, ox, oy, 0);
        check({tag, "_done_count"}, 32'(done_cnt - dc0), 32'd1);
    endtask

    initial begin
        int e0, d, d1, d2, dc0, low;
        checks   = 0;
        failures = 0;
        done_cnt = 0;
        cyc      = 0;
        max_fb   = 0;
        resetn   = 1'b0;
        start    = 1'b0;
        origin_x = '0;
        origin_y = '0;
        for (int a = 0; a < c_FB_SIZE; a++) fb[a] = 9'(a);

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wren", 32'(buf_wren), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_buf_addr", 32'(buf_addr), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // full capture at the origin with an address-valued framebuffer
        capture(0, 0, "origin");
        if (wq.size() >= 400) check("origin_last_pixel", 32'(wq[399][8:0]), 32'h1F3);
        else check("origin_last_pixel", 32'(wq.size()), 32'd400);

        // remaining captures use random framebuffer contents
        for (int a = 0; a < c_FB_SIZE; a++) fb[a] = 9'($urandom);

        // clipped corner capture
        max_fb = 0;
        capture(150, 110, "clip");
        if (wq.size() >= 1) check("clip_first_pixel", 32'(wq[0][8:0]), 32'(fb[110 * 160 + 150]));
        else check("clip_first_pixel", 32'(wq.size()), 32'd1);
        check("clip_max_fb_addr", 32'(max_fb <= 19199), 32'd1);

        // start with new origin while busy must be ignored
        wq.delete();
        dc0 = done_cnt;
        launch(40, 30, e0);
        while (cyc < e0 + 50) @(negedge clk);
        origin_x = 8'd0;
        origin_y = 7'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", d);
        check("ignore_latency", 32'(d - e0), 32'd402);
        repeat (20) @(negedge clk);
        check("ignore_nwrites", 32'(wq.size()), 32'd400);
        check_writes("ignore", 40, 30, 0);
        check("ignore_done_count", 32'(done_cnt - dc0), 32'd1);

        // random origins, including partially clipped ones
        for (int i = 0; i < 3; i++) begin
            capture(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), "rand");
        end

        // one-cycle reset in the middle of a capture
        dc0 = done_cnt;
        launch(int'($urandom_range(0, 140)), int'($urandom_range(0, 100)), e0);
        while (cyc < e0 + 100) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wren", 32'(buf_wren), 32'd0);
        repeat (450) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - dc0), 32'd0);
        capture(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), "after_rst");

        // start held high across done: back-to-back captures
        wq.delete();
        dc0 = done_cnt;
        @(negedge clk);
        origin_x = 8'd70;
        origin_y = 7'd55;
        start    = 1'b1;
        @(negedge clk);
        e0 = cyc;
        wait_done("held1", d1);
        check("held1_latency", 32'(d1 - e0), 32'd402);
        low = 1;
        while (busy === 1'b0 && low < 10) begin
            @(negedge clk);
            if (busy === 1'b0) low++;
        end
        start = 1'b0;
        check("held_busy_gap", 32'(low), 32'd1);
        wait_done("held2", d2);
        check("held2_latency", 32'(d2 - d1), 32'd403);
        repeat (5) @(negedge clk);
        check("held_done_count", 32'(done_cnt - dc0), 32'd2);
        check("held_nwrites", 32'(wq.size()), 32'd800);
        check_writes("held1", 70, 55, 0);
        check_writes("held2", 70, 55, 400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
